// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, PSR flag bit
// positions and the controller state encoding.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_OR   = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_MUL  = 4'd6;
  localparam logic [3:0] OP_CMP  = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_DIVU = 4'd11;
  localparam logic [3:0] OP_REMU = 4'd12;

  // PSR layout {C,L,F,Z,N}
  localparam int FLG_C = 4;
  localparam int FLG_L = 3;
  localparam int FLG_F = 2;
  localparam int FLG_Z = 1;
  localparam int FLG_N = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_seq_if.sv
// Operation/result handshake bundle of the sequential ALU.
// master: controller side; slave: the ALU.
interface alu_seq_if #(
  parameter int WIDTH     = 32,
  parameter int ALUOPBITS = 4,
  parameter int REGBITS   = 5
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     arg1;
  logic [WIDTH-1:0]     arg2;
  logic [ALUOPBITS-1:0] aluop;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     result;
  logic [REGBITS-1:0]   psr;

  modport master (
    output in_valid, arg1, arg2, aluop, out_ready,
    input  in_ready, out_valid, result, psr
  );

  modport slave (
    input  in_valid, arg1, arg2, aluop, out_ready,
    output in_ready, out_valid, result, psr
  );
endinterface

// File: rtl/alu_seq_iter.sv
// Shared iterative engine: shift-add multiply / restoring divide.
// Ports: start_i/div_i/a_i/b_i load, done_o marks the final step, acc_o/opa_o.
module alu_seq_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] opa_o
);
  localparam int CW = $clog2(WIDTH);

  logic             busy_q;
  logic             div_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH:0]   t;
  logic             ge;

  // mul: acc=product, opa=multiplicand, opb=multiplier
  // div: acc=partial remainder, opa=dividend/quotient, opb=divisor
  always_comb begin
    t     = {acc_q, opa_q[WIDTH-1]};
    ge    = t >= {1'b0, opb_q};
    acc_d = acc_q;
    opa_d = opa_q;
    opb_d = opb_q;
    if (div_q) begin
      acc_d = ge ? (t[WIDTH-1:0] - opb_q) : t[WIDTH-1:0];
      opa_d = {opa_q[WIDTH-2:0], ge};
    end else begin
      acc_d = acc_q + (opb_q[0] ? opa_q : '0);
      opa_d = opa_q << 1;
      opb_d = opb_q >> 1;
    end
  end

  // Final step's values are presented combinationally with done_o
  assign done_o = busy_q && (cnt_q == '0);
  assign acc_o  = acc_d;
  assign opa_o  = opa_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= 1'b0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
      opa_q  <= '0;
      opb_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      div_q  <= div_i;
      cnt_q  <= CW'(WIDTH - 1);
      acc_q  <= '0;
      opa_q  <= a_i;
      opb_q  <= b_i;
    end else if (busy_q) begin
      acc_q <= acc_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == '0) busy_q <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with registered result/PSR and valid/ready handshake.
// Ports: clk, reset (async active-low), bus (alu_seq_if.slave).
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int ALUOPBITS = 4,
  parameter int REGBITS   = 5
) (
  input  logic     clk,
  input  logic     reset,
  alu_seq_if.slave bus
);
  localparam int SHBITS = $clog2(WIDTH);

  state_e state_q, state_d;

  logic [3:0]         op;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   a, b;
  logic [SHBITS-1:0]  sh;
  logic               in_ready;
  logic               accept;
  logic               is_mul, is_dv, div0;
  logic               start, sc_wr, fin_wr;

  logic [WIDTH:0]     sum, diff;
  logic [WIDTH-1:0]   sc_res, fin_res;
  logic [REGBITS-1:0] sc_flg, fin_flg;

  logic               it_done;
  logic [WIDTH-1:0]   it_acc, it_opa;

  logic               ov_q, ov_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [REGBITS-1:0] psr_q, psr_d;

  assign op = bus.aluop[3:0];
  assign a  = bus.arg1;
  assign b  = bus.arg2;
  assign sh = b[SHBITS-1:0];

  assign in_ready = (state_q == ST_IDLE) && (!ov_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  assign is_mul = op == OP_MUL;
  assign is_dv  = (op == OP_DIVU) || (op == OP_REMU);
  assign div0   = is_dv && (b == '0);
  // Divide by zero resolves in one cycle
  assign start  = accept && (is_mul || (is_dv && !div0));
  assign sc_wr  = accept && !start;
  assign fin_wr = (state_q != ST_IDLE) && it_done;

  alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
    .clk     (clk),
    .reset   (reset),
    .start_i (start),
    .div_i   (is_dv),
    .a_i     (a),
    .b_i     (b),
    .done_o  (it_done),
    .acc_o   (it_acc),
    .opa_o   (it_opa)
  );

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} - {1'b0, b};
    sc_res = sum[WIDTH-1:0];
    sc_flg = '0;
    case (op)
      OP_ADD: begin
        sc_res        = sum[WIDTH-1:0];
        sc_flg[FLG_C] = sum[WIDTH];
        sc_flg[FLG_F] = (a[WIDTH-1] == b[WIDTH-1]) &&
                        (sc_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res        = diff[WIDTH-1:0];
        sc_flg[FLG_C] = diff[WIDTH];
        sc_flg[FLG_F] = (a[WIDTH-1] != b[WIDTH-1]) &&
                        (sc_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_CMP: begin
        sc_res        = diff[WIDTH-1:0];
        sc_flg[FLG_L] = diff[WIDTH];
        sc_flg[FLG_Z] = a == b;
        sc_flg[FLG_N] = $signed(a) < $signed(b);
      end
      OP_OR, OP_AND, OP_XOR, OP_NOT,
      OP_SLL, OP_SRL, OP_SRA: begin
        case (op)
          OP_OR:   sc_res = a | b;
          OP_AND:  sc_res = a & b;
          OP_XOR:  sc_res = a ^ b;
          OP_NOT:  sc_res = ~a;
          OP_SLL:  sc_res = a << sh;
          OP_SRL:  sc_res = a >> sh;
          default: sc_res = $signed(a) >>> sh;
        endcase
        sc_flg[FLG_Z] = sc_res == '0;
      end
      OP_DIVU: begin
        sc_res        = '1;
        sc_flg[FLG_F] = 1'b1;
      end
      OP_REMU: begin
        sc_res        = a;
        sc_flg[FLG_F] = 1'b1;
        sc_flg[FLG_Z] = a == '0;
      end
      default: begin
        sc_res = sum[WIDTH-1:0];
        sc_flg = '0;
      end
    endcase
  end

  always_comb begin
    if (state_q == ST_MUL || op_q == OP_MUL)
      fin_res = it_acc;
    else if (op_q == OP_DIVU)
      fin_res = it_opa;
    else
      fin_res = it_acc;
    fin_flg        = '0;
    fin_flg[FLG_Z] = fin_res == '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      ov_q    <= 1'b0;
      res_q   <= '0;
      psr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) op_q <= op;
      ov_q    <= ov_d;
      res_q   <= res_d;
      psr_q   <= psr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = is_mul ? ST_MUL : ST_DIV;
      ST_MUL,
      ST_DIV:  if (it_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Drain clears valid unless a new result lands on the same edge
  always_comb begin
    ov_d  = ov_q && !bus.out_ready;
    res_d = res_q;
    psr_d = psr_q;
    if (sc_wr) begin
      ov_d  = 1'b1;
      res_d = sc_res;
      psr_d = sc_flg;
    end else if (fin_wr) begin
      ov_d  = 1'b1;
      res_d = fin_res;
      psr_d = fin_flg;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = ov_q;
  assign bus.result    = res_q;
  assign bus.psr       = psr_q;
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Sequential, parametrised successor to the single-cycle combinational ALU in the CPU datapath.
- Results and the PSR flag word are registered.
- Adds shifts, iterative unsigned divide/remainder and an iterative multiplier.
- Uses a valid/ready handshake so the controller can stall on multi-cycle operations.
- Sits between the RegFile/immediate mux and the writeback stage. The PSR register moves inside this block.

Parameters:
WIDTH, 32, datapath width (>=4, power of two)
ALUOPBITS, 4, opcode width
REGBITS, 5, PSR width; flag order {C,L,F,Z,N}
SHBITS, $clog2(WIDTH), localparam; shift amount width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  operands/opcode present
in_ready  out  1  block can accept an operation this cycle
arg1  in  WIDTH  Rs operand
arg2  in  WIDTH  Rt or immediate operand
aluop  in  ALUOPBITS  operation select
out_valid  out  1  result/psr valid; held until out_ready
out_ready  in  1  consumer takes result
result  out  WIDTH  operation result
psr  out  REGBITS  flags of the most recently completed operation

Behaviour:
- Reset (reset=0, async): state=IDLE, out_valid=0, result=0, psr=0, iteration counter=0.
- Accept: an operation is accepted on a clock edge where in_valid && in_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready). A same-cycle drain and accept is legal.
  - Operands and opcode are captured internally. arg1, arg2 and aluop may change after acceptance.
- Opcodes:
  - 0 ADD, 1 SUB, 2 OR, 3 AND, 4 XOR, 5 NOT(arg1)
  - 6 MUL: low WIDTH bits of the product; identical for signed and unsigned
  - 7 CMP: result = arg1-arg2
  - 8 SLL, 9 SRL, 10 SRA: shift amount = arg2[SHBITS-1:0]
  - 11 DIVU, 12 REMU
  - 13-15 reserved: result = arg1+arg2, psr flags = 0
- Flags, computed on completion (unlisted flags = 0):
  - ADD: C = carry out of bit WIDTH-1; F = signed overflow (operand signs equal and differ from result sign).
  - SUB: C = borrow (arg1 <u arg2); F = signed overflow (operand signs differ and result sign != arg1 sign).
  - CMP: L = arg1 <u arg2; Z = (arg1==arg2); N = arg1 <s arg2.
  - Logic, shift and MUL ops: Z = (result==0).
  - DIVU/REMU: F = divide-by-zero; Z = (result==0).
- Latency, with accept at edge t:
  - Single-cycle ops (0-5, 7-10, reserved): out_valid=1 after edge t+1.
  - MUL: shift-add, one bit per cycle, WIDTH iterations; out_valid after edge t+WIDTH+1.
  - DIVU/REMU with arg2!=0: restoring division, WIDTH iterations; out_valid after edge t+WIDTH+1.
  - DIVU/REMU with arg2==0: no iteration; out_valid after edge t+1. DIVU result = all ones; REMU result = arg1; F=1.
- States:
  - IDLE -> EXEC_MUL | EXEC_DIV on accept of a multi-cycle op (counter loaded with WIDTH-1). Single-cycle ops write the output register directly and stay in IDLE.
  - EXEC_* decrements the counter each cycle. At counter==0, write result/psr, set out_valid, return to IDLE.
- Output hold: result, psr and out_valid stay stable while out_valid && !out_ready. Draining (out_ready=1) clears out_valid unless a new result is written on the same edge.
- psr changes only when a new result is written; it is not cleared on drain.
- Reset mid-iteration aborts the operation; no partial result is ever presented.
- in_valid while busy: ignored (in_ready=0); the operation is not captured.

Decomposition:
- Shared package alu_pkg: opcode localparams (ADD..REMU), flag bit indices (C=4,L=3,F=2,Z=1,N=0), state encoding.
- One natural sub-module: alu_seq_iter, the shared shift-add / restoring-divide engine (accumulator, shifting operand, counter, done pulse). The top holds the handshake, single-cycle datapath and the PSR/output register.

Test Plan:
- ADD 0xFFFFFFFF+0x00000001 -> out_valid 1 cycle later; result 0, psr C=1, F=0.
- ADD 0x7FFFFFFF+1 -> result 0x80000000, F=1. CMP 0xFFFFFFFE vs 0x1 -> L=0, N=1, Z=0. CMP 5 vs 5 -> Z=1.
- MUL 0x12345 * 0x10 -> out_valid exactly 33 cycles after accept, result 0x123450. in_ready=0 throughout; a second in_valid during this window is not accepted.
- DIVU 100/7 -> result 14 after 33 cycles. REMU 100/7 -> 2. DIVU 9/0 -> 0xFFFFFFFF with F=1 after 1 cycle.
- Backpressure: hold out_ready=0 for 5 cycles after an SRA 0x80000000 by 4 -> result remains 0xF8000000 and in_ready=0. Raising out_ready together with in_valid (ADD 1+1) drains and accepts on the same edge; next result is 2.
- Assert reset low mid-DIVU -> outputs 0 immediately; after release, in_ready=1 and no stale out_valid appears.
